// File: rtl/epd_panel_rx_pkg.sv
// Shared definitions for the EPD panel-side receiver; the readout state
// encodings and default line length match the output controller.
package epd_panel_rx_pkg;

  localparam int H_ACT_DEF = 40;
  localparam int COL_W     = 6;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

endpackage

// File: rtl/epd_panel_rx_if.sv
// Readout stream of the panel receiver: one captured beat per valid/ready
// transfer, tagged with its gate row and column.
interface epd_panel_rx_if #(
  parameter int ROW_W = 11
);
  import epd_panel_rx_pkg::*;

  logic [7:0]       out_data;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data, out_row, out_col, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row, out_col, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/epd_pingpong_buf.sv
// Two H_ACT x 8 line banks: one filled from the panel pins while the other
// is read out combinationally by column.
module epd_pingpong_buf
  import epd_panel_rx_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             rd_bank,
  input  logic [COL_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem_q [2][H_ACT];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank][wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/epd_panel_rx.sv
// Reconstructs lines and frames from the EPD panel control pins and replays
// each latched line as a valid/ready beat stream with row/column tags.
module epd_panel_rx
  import epd_panel_rx_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int ROW_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        epd_gdoe,
  input  logic        epd_gdclk,
  input  logic        epd_gdsp,
  input  logic        epd_sdle,
  input  logic        epd_sdoe,
  input  logic        epd_sdce0,
  input  logic [7:0]  epd_sd,
  epd_panel_rx_if.master out_if,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        len_err,
  output logic        ovr_err,
  input  logic        err_clr
);

  localparam logic [COL_W-1:0] H_MAX = COL_W'(H_ACT);

  rd_state_e        state_q;
  logic [COL_W-1:0] wr_cnt_q, wr_cnt_d, len_q, col_q;
  logic [ROW_W-1:0] row_cnt_q, tag_q;
  logic [15:0]      frame_cnt_q;
  logic             wr_bank_q, sdle_q, gdclk_q, gdoe_q;
  logic             frame_done_q, len_err_q, ovr_err_q;

  logic             latch, last, xfer, rd_free, accept, beat, drop, wr_bank_sel;
  logic             len_set, ovr_set;
  logic [COL_W-1:0] wr_base;
  logic [7:0]       rd_data;
  logic             unused_sdoe;

  assign unused_sdoe = epd_sdoe;

  // A beat arriving in the latch cycle lands at index 0 of whichever bank is
  // the write bank after the latch (swapped on accept, reused on overrun).
  always_comb begin
    latch       = epd_sdle && !sdle_q && (wr_cnt_q != '0);
    last        = (state_q == RD_DRAIN) && (col_q == len_q - 1'b1);
    xfer        = (state_q == RD_DRAIN) && out_if.out_ready;
    rd_free     = (state_q == RD_IDLE) || (xfer && last);
    accept      = latch && rd_free;
    wr_base     = latch ? '0 : wr_cnt_q;
    beat        = !epd_sdce0 && (wr_base != H_MAX);
    drop        = !epd_sdce0 && (wr_base == H_MAX);
    wr_bank_sel = accept ? ~wr_bank_q : wr_bank_q;
    wr_cnt_d    = beat ? wr_base + 1'b1 : wr_base;
    len_set     = drop || (latch && (wr_cnt_q != H_MAX));
    ovr_set     = latch && !rd_free;
  end

  epd_pingpong_buf #(.H_ACT(H_ACT)) u_buf (
    .clk     (clk),
    .wr_en   (beat),
    .wr_bank (wr_bank_sel),
    .wr_addr (wr_base),
    .wr_data (epd_sd),
    .rd_bank (~wr_bank_q),
    .rd_addr (col_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RD_IDLE;
      wr_cnt_q     <= '0;
      len_q        <= '0;
      col_q        <= '0;
      row_cnt_q    <= '0;
      tag_q        <= '0;
      frame_cnt_q  <= '0;
      wr_bank_q    <= 1'b0;
      sdle_q       <= 1'b0;
      gdclk_q      <= 1'b0;
      gdoe_q       <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      ovr_err_q    <= 1'b0;
    end else begin
      sdle_q       <= epd_sdle;
      gdclk_q      <= epd_gdclk;
      gdoe_q       <= epd_gdoe;
      wr_cnt_q     <= wr_cnt_d;
      frame_done_q <= gdoe_q && !epd_gdoe;
      if (gdoe_q && !epd_gdoe) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (epd_gdclk && !gdclk_q) begin
        if (!epd_gdsp)       row_cnt_q <= '0;
        else if (!(&row_cnt_q)) row_cnt_q <= row_cnt_q + 1'b1;
      end
      len_err_q <= len_set || (len_err_q && !err_clr);
      ovr_err_q <= ovr_set || (ovr_err_q && !err_clr);

      case (state_q)
        RD_IDLE:  ;
        RD_DRAIN: if (xfer) begin
          if (last) state_q <= RD_IDLE;
          else      col_q   <= col_q + 1'b1;
        end
        default:  state_q <= RD_IDLE;
      endcase
      // An accepted latch starts a fresh drain even on the final transfer.
      if (accept) begin
        state_q   <= RD_DRAIN;
        col_q     <= '0;
        len_q     <= wr_cnt_q;
        tag_q     <= row_cnt_q;
        wr_bank_q <= ~wr_bank_q;
      end
    end
  end

  assign out_if.out_valid = (state_q == RD_DRAIN);
  assign out_if.out_data  = out_if.out_valid ? rd_data : 8'h00;
  assign out_if.out_row   = tag_q;
  assign out_if.out_col   = col_q;
  assign out_if.out_last  = last;
  assign frame_done       = frame_done_q;
  assign frame_cnt        = frame_cnt_q;
  assign len_err          = len_err_q;
  assign ovr_err          = ovr_err_q;

endmodule

// File: tb/tb_epd_panel_rx.sv
// Directed bench for epd_panel_rx: a queue-based line/frame model checked
// every cycle, plus hand-computed expectations on each scenario.
module tb_epd_panel_rx;
  import epd_panel_rx_pkg::*;

  localparam int H_ACT = 40;
  localparam int ROW_W = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       epd_gdoe = 1'b0, epd_gdclk = 1'b0, epd_gdsp = 1'b0;
  logic       epd_sdle = 1'b0, epd_sdoe = 1'b0, epd_sdce0 = 1'b1;
  logic [7:0] epd_sd = 8'h00;
  logic       err_clr = 1'b0;
  logic       frame_done, len_err, ovr_err;
  logic [15:0] frame_cnt;

  epd_panel_rx_if #(.ROW_W(ROW_W)) oif ();

  epd_panel_rx #(.H_ACT(H_ACT), .ROW_W(ROW_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .epd_gdoe   (epd_gdoe),
    .epd_gdclk  (epd_gdclk),
    .epd_gdsp   (epd_gdsp),
    .epd_sdle   (epd_sdle),
    .epd_sdoe   (epd_sdoe),
    .epd_sdce0  (epd_sdce0),
    .epd_sd     (epd_sd),
    .out_if     (oif.master),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .len_err    (len_err),
    .ovr_err    (ovr_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the line being written, the line being read out, and
  // the gate/frame/error bookkeeping, updated once per rising edge.
  logic [7:0] m_wr[$];
  logic [7:0] m_rd[$];
  int  m_idx, m_tag, m_row, m_fcnt;
  bit  m_drain, m_fd, m_len, m_ovr;
  bit  p_sdle, p_gdclk, p_gdoe;
  bit  lenset, ovrset, lat, fin;

  always @(posedge clk) begin
    if (rst) begin
      m_wr.delete(); m_rd.delete();
      m_idx = 0; m_tag = 0; m_row = 0; m_fcnt = 0;
      m_drain = 0; m_fd = 0; m_len = 0; m_ovr = 0;
      p_sdle = 0; p_gdclk = 0; p_gdoe = 0;
    end else begin
      lenset = 0; ovrset = 0;
      fin = m_drain && oif.out_ready && (m_idx == m_rd.size() - 1);
      if (m_drain && oif.out_ready) m_idx++;
      if (fin) m_drain = 0;
      lat = epd_sdle && !p_sdle && (m_wr.size() > 0);
      if (lat) begin
        if (m_wr.size() != H_ACT) lenset = 1;
        if (!m_drain) begin
          m_rd = m_wr; m_tag = m_row; m_idx = 0; m_drain = 1;
        end else ovrset = 1;
        m_wr.delete();
      end
      if (!epd_sdce0) begin
        if (m_wr.size() < H_ACT) m_wr.push_back(epd_sd);
        else lenset = 1;
      end
      if (epd_gdclk && !p_gdclk)
        m_row = epd_gdsp ? ((m_row == (2**ROW_W) - 1) ? m_row : m_row + 1) : 0;
      m_fd = p_gdoe && !epd_gdoe;
      if (m_fd) m_fcnt = (m_fcnt + 1) % 65536;
      m_len = lenset || (m_len && !err_clr);
      m_ovr = ovrset || (m_ovr && !err_clr);
      p_sdle = epd_sdle; p_gdclk = epd_gdclk; p_gdoe = epd_gdoe;
    end
  end

  int xfer_cnt = 0, fd_cnt = 0;
  logic [31:0] last_col = 0, last_dat = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", oif.out_valid, m_drain);
      if (m_drain) begin
        chk("out_data", oif.out_data, m_rd[m_idx]);
        chk("out_col",  oif.out_col, m_idx);
        chk("out_row",  oif.out_row, m_tag);
        chk("out_last", oif.out_last, (m_idx == m_rd.size() - 1));
      end
      chk("frame_done", frame_done, m_fd);
      chk("frame_cnt",  frame_cnt, m_fcnt);
      chk("len_err",    len_err, m_len);
      chk("ovr_err",    ovr_err, m_ovr);
      if (oif.out_valid && oif.out_ready) begin
        xfer_cnt++;
        if (oif.out_last) begin
          last_col = oif.out_col;
          last_dat = oif.out_data;
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      epd_sdce0 = 1'b0;
      epd_sd    = 8'(base + i);
      tick();
    end
    epd_sdce0 = 1'b1;
  endtask

  task automatic do_latch();
    epd_sdle = 1'b1; tick();
    epd_sdle = 1'b0; tick();
  endtask

  task automatic gd_pulse(input logic sp);
    epd_gdsp = sp; epd_gdclk = 1'b1; tick();
    epd_gdclk = 1'b0; tick();
  endtask

  task automatic clear_errs();
    err_clr = 1'b1; tick();
    err_clr = 1'b0; tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (oif.out_valid && n < 500) begin
      tick();
      n++;
    end
    chk(name, oif.out_valid, 1'b0);
    tick();
  endtask

  task automatic clr_mon();
    xfer_cnt = 0; last_col = 0; last_dat = 0;
  endtask

  initial begin
    oif.out_ready = 1'b1;
    tick(); tick();
    chk_en = 1;
    chk("rst_valid", oif.out_valid, 1'b0);
    chk("rst_fcnt",  frame_cnt, 16'd0);
    chk("rst_errs",  {len_err, ovr_err}, 2'b00);
    rst = 1'b0;
    tick();

    // Full line, straight readout
    clr_mon();
    send(40, 0);
    do_latch();
    wait_idle("idle_full");
    chk("full_xfers", xfer_cnt, 40);
    chk("full_lastcol", last_col, 39);
    chk("full_lastdat", last_dat, 8'h27);
    chk("full_errs", {len_err, ovr_err}, 2'b00);

    // Row tracking
    gd_pulse(1'b0);
    gd_pulse(1'b1); gd_pulse(1'b1); gd_pulse(1'b1);
    send(40, 8'h20);
    do_latch();
    chk("row_tag", oif.out_row, 3);
    wait_idle("idle_row");

    // Overrun while stalled
    oif.out_ready = 1'b0;
    clr_mon();
    send(40, 8'h40);
    do_latch();
    send(40, 8'h80);
    do_latch();
    chk("ovr_set", ovr_err, 1'b1);
    chk("ovr_hold_dat", oif.out_data, 8'h40);
    chk("ovr_hold_col", oif.out_col, 0);
    oif.out_ready = 1'b1;
    wait_idle("idle_ovr");
    chk("ovr_xfers", xfer_cnt, 40);
    chk("ovr_lastdat", last_dat, 8'h67);
    clear_errs();

    // Short line, then overlong line
    clr_mon();
    send(30, 0);
    do_latch();
    chk("short_len_err", len_err, 1'b1);
    wait_idle("idle_short");
    chk("short_xfers", xfer_cnt, 30);
    chk("short_lastcol", last_col, 29);
    clear_errs();
    clr_mon();
    send(45, 0);
    chk("long_len_err", len_err, 1'b1);
    do_latch();
    wait_idle("idle_long");
    chk("long_xfers", xfer_cnt, 40);
    chk("long_lastcol", last_col, 39);
    chk("long_lastdat", last_dat, 8'h27);

    // Frame ends and error clear
    for (int k = 0; k < 3; k++) begin
      epd_gdoe = 1'b1; tick();
      epd_gdoe = 1'b0; tick(); tick();
    end
    chk("frame_pulses", fd_cnt, 3);
    chk("frame_cnt3", frame_cnt, 16'd3);
    clear_errs();
    chk("errs_cleared", {len_err, ovr_err}, 2'b00);

    // Reset mid-readout
    send(40, 0);
    do_latch();
    begin
      int n = 0;
      while (!(oif.out_valid && oif.out_col == 6'd20) && n < 200) begin
        tick();
        n++;
      end
    end
    chk("reach_col20", oif.out_col, 20);
    rst = 1'b1; tick();
    chk("rst_mid_valid", oif.out_valid, 1'b0);
    chk("rst_mid_fcnt", frame_cnt, 16'd0);
    rst = 1'b0; tick();
    clr_mon();
    send(40, 8'h10);
    do_latch();
    wait_idle("idle_after_rst");
    chk("post_rst_xfers", xfer_cnt, 40);
    chk("post_rst_lastdat", last_dat, 8'h37);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
